inst_decode_stage: RTL

//  Registered RV32I decode stage between fetch and register-read; generalises the standalone J-format decoder to all formats.

---
 rtl/dec_pkg.sv | 50 +++++
 rtl/inst_imm_gen.sv | 50 +++++
 rtl/inst_decode_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared decode definitions: RV32I opcodes, format classes, skid-buffer states
// and the decoded-field record stored in each buffer slot.
package dec_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        T_R   = 3'd0,
        T_I   = 3'd1,
        T_S   = 3'd2,
        T_B   = 3'd3,
        T_U   = 3'd4,
        T_J   = 3'd5,
        T_ILL = 3'd7
    } ins_type_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        ins_type_e  typ;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       illegal;
    } dec_fields_t;

    localparam int DEC_FIELDS_W = $bits(dec_fields_t);

    // Stores, branches and illegal words have no destination register.
    function automatic logic [4:0] dec_rd(input ins_type_e typ, input logic [4:0] rd_raw);
        return (typ == T_S || typ == T_B || typ == T_ILL) ? 5'd0 : rd_raw;
    endfunction

endpackage

// File: rtl/inst_imm_gen.sv
// Combinational RV32I format classifier and immediate generator;
// every immediate is built as 32 bits and then sign-extended to XLEN.
module inst_imm_gen
    import dec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IMM_ZERO = 1
) (
    input  logic [31:0]     i_instr,
    output ins_type_e       o_type,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic signed [31:0] w_imm32;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        o_type = T_ILL;
        if (i_instr[1:0] == 2'b11) begin
            case (i_instr[6:0])
                OP_R:                                        o_type = T_R;
                OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: o_type = T_I;
                OP_STORE:                                    o_type = T_S;
                OP_BRANCH:                                   o_type = T_B;
                OP_LUI, OP_AUIPC:                            o_type = T_U;
                OP_JAL:                                      o_type = T_J;
                default:                                     o_type = T_ILL;
            endcase
        end
    end

    always_comb begin
        w_imm32 = '0;
        case (o_type)
            T_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            T_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            T_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
            T_U: w_imm32 = {i_instr[31:12], 12'b0};
            T_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: w_imm32 = (IMM_ZERO != 0) ? 32'sd0 : {{20{i_instr[31]}}, i_instr[31:20]};
        endcase
    end

    assign o_imm     = XLEN'(w_imm32);
    assign o_illegal = (o_type == T_ILL);

endmodule

// File: rtl/inst_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer; decode happens at the
// input so both slots hold decoded entries. Optional macro DEC_JAL_TARGET_EN adds out_jal/out_jal_target.
module inst_decode_stage
    import dec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IMM_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_type,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
`ifdef DEC_JAL_TARGET_EN
    output logic            out_jal,
    output logic [XLEN-1:0] out_jal_target,
`endif
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
`ifdef DEC_JAL_TARGET_EN
        logic            jal;
        logic [XLEN-1:0] jal_target;
`endif
    } entry_t;

    skid_state_e     r_state;
    skid_state_e     w_next_state;
    entry_t          r_out;
    entry_t          r_skid;
    entry_t          w_dec;
    ins_type_e       w_type;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_in_xfer;
    logic            w_out_xfer;

    inst_imm_gen #(.XLEN(XLEN), .IMM_ZERO(IMM_ZERO)) u_imm_gen (
        .i_instr   (in_instr),
        .o_type    (w_type),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = in_pc;
        w_dec.imm      = w_imm;
        w_dec.f.typ    = w_type;
        w_dec.f.rd     = dec_rd(w_type, in_instr[11:7]);
        w_dec.f.rs1    = in_instr[19:15];
        w_dec.f.rs2    = in_instr[24:20];
        w_dec.f.funct3 = in_instr[14:12];
        w_dec.f.funct7 = in_instr[31:25];
        w_dec.f.illegal = w_illegal;
`ifdef DEC_JAL_TARGET_EN
        w_dec.jal        = (w_type == T_J);
        w_dec.jal_target = in_pc + w_imm;
`endif
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_xfer) w_next_state = S_ONE;
                S_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_next_state = S_TWO;
                    else if (!w_in_xfer && w_out_xfer) w_next_state = S_EMPTY;
                end
                S_TWO:   if (w_out_xfer) w_next_state = S_ONE;
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    // Both flow-control outputs decode straight from the state flop.
    always_comb begin
        out_valid = (r_state != S_EMPTY);
        in_ready  = (r_state != S_TWO);
    end

    // NOTE: the slots are cleared on reset because the data outputs must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_xfer) r_out <= w_dec;
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) r_out  <= w_dec;
                    else if (w_in_xfer)          r_skid <= w_dec;
                end
                S_TWO:   if (w_out_xfer) r_out <= r_skid;
                default: ;
            endcase
        end
    end

    assign out_pc      = r_out.pc;
    assign out_type    = r_out.f.typ;
    assign out_rd      = r_out.f.rd;
    assign out_rs1     = r_out.f.rs1;
    assign out_rs2     = r_out.f.rs2;
    assign out_funct3  = r_out.f.funct3;
    assign out_funct7  = r_out.f.funct7;
    assign out_imm     = r_out.imm;
    assign out_illegal = r_out.f.illegal;
`ifdef DEC_JAL_TARGET_EN
    assign out_jal        = r_out.jal;
    assign out_jal_target = r_out.jal_target;
`endif

endmodule
